// File: rtl/tl_probe_engine_if.sv
// Bundle of the probe engine's job request, TileLink B/C channels, writeback
// stream and completion report; "slave" is the engine side, "master" the environment.
interface tl_probe_engine_if #(
    parameter int unsigned NUM_CLIENTS = 2,
    parameter int unsigned SRC_W       = 4,
    parameter int unsigned ADDR_W      = 64,
    parameter int unsigned DATA_W      = 64
);
    logic                   req_valid_i;
    logic                   req_ready_o;
    logic [ADDR_W-1:0]      req_addr_i;
    logic [2:0]             req_param_i;
    logic [NUM_CLIENTS-1:0] req_mask_i;

    logic                   tl_b_valid_o;
    logic                   tl_b_ready_i;
    logic [2:0]             tl_b_opcode_o;
    logic [2:0]             tl_b_param_o;
    logic [3:0]             tl_b_size_o;
    logic [SRC_W-1:0]       tl_b_source_o;
    logic [ADDR_W-1:0]      tl_b_address_o;
    logic [DATA_W/8-1:0]    tl_b_mask_o;

    logic                   tl_c_valid_i;
    logic                   tl_c_ready_o;
    logic [2:0]             tl_c_opcode_i;
    logic [2:0]             tl_c_param_i;
    logic [SRC_W-1:0]       tl_c_source_i;
    logic [ADDR_W-1:0]      tl_c_address_i;
    logic [DATA_W-1:0]      tl_c_data_i;
    logic                   tl_c_corrupt_i;

    logic                   wb_valid_o;
    logic                   wb_ready_i;
    logic [DATA_W-1:0]      wb_data_o;
    logic                   wb_last_o;

    logic                   done_o;
    logic [NUM_CLIENTS-1:0] done_acked_o;
    logic                   done_dirty_o;
    logic                   done_err_o;

    modport slave (
        input  req_valid_i, req_addr_i, req_param_i, req_mask_i,
        input  tl_b_ready_i,
        input  tl_c_valid_i, tl_c_opcode_i, tl_c_param_i, tl_c_source_i,
        input  tl_c_address_i, tl_c_data_i, tl_c_corrupt_i,
        input  wb_ready_i,
        output req_ready_o,
        output tl_b_valid_o, tl_b_opcode_o, tl_b_param_o, tl_b_size_o,
        output tl_b_source_o, tl_b_address_o, tl_b_mask_o,
        output tl_c_ready_o,
        output wb_valid_o, wb_data_o, wb_last_o,
        output done_o, done_acked_o, done_dirty_o, done_err_o
    );

    modport master (
        output req_valid_i, req_addr_i, req_param_i, req_mask_i,
        output tl_b_ready_i,
        output tl_c_valid_i, tl_c_opcode_i, tl_c_param_i, tl_c_source_i,
        output tl_c_address_i, tl_c_data_i, tl_c_corrupt_i,
        output wb_ready_i,
        input  req_ready_o,
        input  tl_b_valid_o, tl_b_opcode_o, tl_b_param_o, tl_b_size_o,
        input  tl_b_source_o, tl_b_address_o, tl_b_mask_o,
        input  tl_c_ready_o,
        input  wb_valid_o, wb_data_o, wb_last_o,
        input  done_o, done_acked_o, done_dirty_o, done_err_o
    );
endinterface

// File: rtl/tl_probe_engine.sv
// Manager-side probe sequencer: probes each selected client on B, collects C acks,
// forwards one dirty line to writeback. Optional watchdog: TL_PROBE_TIMEOUT_EN.
module tl_probe_engine #(
    parameter int unsigned NUM_CLIENTS    = 2,
    parameter int unsigned SRC_BASE       = 0,
    parameter int unsigned SRC_W          = 4,
    parameter int unsigned ADDR_W         = 64,
    parameter int unsigned DATA_W         = 64,
    parameter int unsigned BEATS          = 8
`ifdef TL_PROBE_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic               clk_i,
    input  logic               rst_i,
    tl_probe_engine_if.slave   io
);
    localparam int unsigned BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [2:0]  OP_PROBE   = 3'd6;
    localparam logic [2:0]  OP_ACK     = 3'd4;
    localparam logic [2:0]  OP_ACKDATA = 3'd5;
    localparam logic [2:0]  PARAM_MAX  = 3'd5;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_COLLECT, S_DONE} state_t;

    state_t                 r_state;
    logic [ADDR_W-1:0]      r_addr;
    logic [2:0]             r_param;
    logic [NUM_CLIENTS-1:0] r_todo;
    logic [NUM_CLIENTS-1:0] r_pending;
    logic [NUM_CLIENTS-1:0] r_acked;
    logic                   r_dirty;
    logic                   r_err;
    logic [BEAT_W-1:0]      r_beat;
    logic [SRC_W-1:0]       r_burst_src;
    logic                   r_burst_fwd;

    logic                   w_active;
    logic                   w_b_valid;
    logic                   w_b_fire;
    logic [SRC_W-1:0]       w_b_idx;
    logic [NUM_CLIENTS-1:0] w_b_onehot;
    logic [SRC_W:0]         w_c_off;
    logic [NUM_CLIENTS-1:0] w_c_onehot;
    logic                   w_src_ok;
    logic                   w_is_ack;
    logic                   w_is_data;
    logic                   w_first;
    logic                   w_last;
    logic                   w_fwd;
    logic                   w_c_ready;
    logic                   w_c_fire;
    logic                   w_c_err;
    logic                   w_wb_valid;
    logic [NUM_CLIENTS-1:0] w_ack_set;
    logic [NUM_CLIENTS-1:0] w_b_set;
    logic [NUM_CLIENTS-1:0] w_todo_nxt;
    logic [NUM_CLIENTS-1:0] w_pending_nxt;

    assign w_active  = (r_state == S_SEND) || (r_state == S_COLLECT);
    assign w_b_valid = (r_state == S_SEND) && (|r_todo);
    assign w_b_fire  = w_b_valid && io.tl_b_ready_i;

    // Lowest outstanding client gets the next probe
    always_comb begin
        w_b_idx = '0;
        for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
            if (r_todo[i]) w_b_idx = SRC_W'(i);
        end
    end
    assign w_b_onehot = NUM_CLIENTS'(1) << w_b_idx;

    // Out-of-range sources (below SRC_BASE or beyond the last client) decode to no client
    assign w_c_off = {1'b0, io.tl_c_source_i} - (SRC_W+1)'(SRC_BASE);
    always_comb begin
        w_c_onehot = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            w_c_onehot[i] = (w_c_off == (SRC_W+1)'(i));
        end
    end

    assign w_src_ok  = |(w_c_onehot & r_pending);
    assign w_is_ack  = (io.tl_c_opcode_i == OP_ACK);
    assign w_is_data = (io.tl_c_opcode_i == OP_ACKDATA);
    assign w_first   = (r_beat == '0);
    assign w_last    = (r_beat == BEAT_W'(BEATS - 1));
    // Only the first legitimate ProbeAckData of a job reaches writeback
    assign w_fwd     = w_is_data && (w_first ? (w_src_ok && !r_dirty) : r_burst_fwd);
    assign w_c_ready = w_active && (w_fwd ? io.wb_ready_i : 1'b1);
    assign w_c_fire  = io.tl_c_valid_i && w_c_ready;
    assign w_wb_valid = w_active && io.tl_c_valid_i && w_fwd;

    assign w_c_err = !w_src_ok
                   || (w_is_data && !w_first && (io.tl_c_source_i != r_burst_src))
                   || (io.tl_c_address_i != r_addr)
                   || io.tl_c_corrupt_i
                   || !(w_is_ack || w_is_data)
                   || (w_is_data && w_first && r_dirty)
                   || (io.tl_c_param_i > PARAM_MAX);

    assign w_ack_set     = (w_c_fire && (w_is_ack || (w_is_data && w_last)))
                           ? (w_c_onehot & r_pending) : '0;
    assign w_b_set       = w_b_fire ? w_b_onehot : '0;
    assign w_todo_nxt    = r_todo & ~w_b_set;
    assign w_pending_nxt = (r_pending | w_b_set) & ~w_ack_set;

`ifdef TL_PROBE_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] r_tmo;
    logic             w_tmo_hit;
    assign w_tmo_hit = w_active && !w_b_fire && !w_c_fire
                       && (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));

    // Watchdog counts consecutive cycles without any B or C handshake
    always_ff @(posedge clk_i) begin
        if (rst_i || !w_active || w_b_fire || w_c_fire) r_tmo <= '0;
        else                                            r_tmo <= r_tmo + TMO_W'(1);
    end
`else
    logic w_tmo_hit;
    assign w_tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_param     <= '0;
            r_todo      <= '0;
            r_pending   <= '0;
            r_acked     <= '0;
            r_dirty     <= 1'b0;
            r_err       <= 1'b0;
            r_beat      <= '0;
            r_burst_src <= '0;
            r_burst_fwd <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (io.req_valid_i) begin
                        r_addr    <= io.req_addr_i;
                        r_param   <= io.req_param_i;
                        r_todo    <= io.req_mask_i;
                        r_pending <= '0;
                        r_state   <= (io.req_mask_i == '0) ? S_DONE : S_SEND;
                    end
                end
                S_SEND, S_COLLECT: begin
                    r_todo    <= w_todo_nxt;
                    r_pending <= w_pending_nxt;
                    r_acked   <= r_acked | w_ack_set;
                    if (w_c_fire && w_c_err) r_err <= 1'b1;
                    if (w_c_fire && w_is_data) begin
                        r_beat <= w_last ? '0 : r_beat + BEAT_W'(1);
                        if (w_first) begin
                            r_burst_src <= io.tl_c_source_i;
                            r_burst_fwd <= w_fwd;
                        end
                        if (w_last && w_fwd) r_dirty <= 1'b1;
                    end
                    if (r_state == S_SEND) begin
                        if (w_todo_nxt == '0) r_state <= S_COLLECT;
                    end else if ((r_pending == '0) && (r_todo == '0)) begin
                        r_state <= S_DONE;
                    end
                    if (w_tmo_hit) begin
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_addr      <= '0;
                    r_param     <= '0;
                    r_todo      <= '0;
                    r_pending   <= '0;
                    r_acked     <= '0;
                    r_dirty     <= 1'b0;
                    r_err       <= 1'b0;
                    r_beat      <= '0;
                    r_burst_src <= '0;
                    r_burst_fwd <= 1'b0;
                end
            endcase
        end
    end

    assign io.req_ready_o    = (r_state == S_IDLE);
    assign io.tl_b_valid_o   = w_b_valid;
    assign io.tl_b_opcode_o  = w_b_valid ? OP_PROBE : 3'd0;
    assign io.tl_b_param_o   = w_b_valid ? r_param : 3'd0;
    assign io.tl_b_size_o    = w_b_valid ? 4'd6 : 4'd0;
    assign io.tl_b_source_o  = w_b_valid ? SRC_W'(SRC_BASE) + w_b_idx : '0;
    assign io.tl_b_address_o = w_b_valid ? r_addr : '0;
    assign io.tl_b_mask_o    = w_b_valid ? '1 : '0;
    assign io.tl_c_ready_o   = w_c_ready;
    assign io.wb_valid_o     = w_wb_valid;
    assign io.wb_data_o      = (w_active && w_fwd) ? io.tl_c_data_i : '0;
    assign io.wb_last_o      = w_wb_valid && w_last;
    assign io.done_o         = (r_state == S_DONE);
    assign io.done_acked_o   = (r_state == S_DONE) ? r_acked : '0;
    assign io.done_dirty_o   = (r_state == S_DONE) && r_dirty;
    assign io.done_err_o     = (r_state == S_DONE) && r_err;
endmodule

// File: tb/tb_tl_probe_engine.sv
// Scoreboard bench for tl_probe_engine: stimulus queues expected B probes,
// writeback beats and completions; a negedge monitor pops and compares them.
module tb_tl_probe_engine;
    localparam int unsigned NC = 2;
    localparam int unsigned SW = 4;
    localparam int unsigned AW = 64;
    localparam int unsigned DW = 64;
    localparam int unsigned NB = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tl_probe_engine_if #(.NUM_CLIENTS(NC), .SRC_W(SW), .ADDR_W(AW), .DATA_W(DW)) bus ();

    tl_probe_engine #(
        .NUM_CLIENTS(NC), .SRC_BASE(0), .SRC_W(SW), .ADDR_W(AW), .DATA_W(DW), .BEATS(NB)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .io   (bus)
    );

    typedef struct packed {
        logic [SW-1:0] src;
        logic [2:0]    param;
        logic [AW-1:0] addr;
    } b_exp_t;
    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } wb_exp_t;
    typedef struct packed {
        logic [NC-1:0] acked;
        logic          dirty;
        logic          err;
    } done_exp_t;

    b_exp_t    exp_b[$];
    wb_exp_t   exp_wb[$];
    done_exp_t exp_done[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Monitor: compares every presented DUT output event against the scoreboard
    always @(negedge clk) begin : mon
        b_exp_t    eb;
        wb_exp_t   ew;
        done_exp_t ed;
        if (bus.tl_b_valid_o === 1'b1 && bus.tl_b_ready_i) begin
            if (exp_b.size() == 0) chk("b_unexpected", 64'd1, 64'd0);
            else begin
                eb = exp_b.pop_front();
                chk("b_source",  64'(bus.tl_b_source_o),  64'(eb.src));
                chk("b_param",   64'(bus.tl_b_param_o),   64'(eb.param));
                chk("b_address", bus.tl_b_address_o,      eb.addr);
                chk("b_opcode",  64'(bus.tl_b_opcode_o),  64'd6);
                chk("b_size",    64'(bus.tl_b_size_o),    64'd6);
                chk("b_mask",    64'(bus.tl_b_mask_o),    64'hFF);
            end
        end
        if (bus.wb_valid_o === 1'b1) begin
            if (exp_wb.size() == 0) chk("wb_unexpected", 64'd1, 64'd0);
            else if (bus.wb_ready_i) begin
                ew = exp_wb.pop_front();
                chk("wb_data", bus.wb_data_o, ew.data);
                chk("wb_last", 64'(bus.wb_last_o), 64'(ew.last));
            end
        end
        if (bus.done_o === 1'b1) begin
            if (exp_done.size() == 0) chk("done_unexpected", 64'd1, 64'd0);
            else begin
                ed = exp_done.pop_front();
                chk("done_acked", 64'(bus.done_acked_o), 64'(ed.acked));
                chk("done_dirty", 64'(bus.done_dirty_o), 64'(ed.dirty));
                chk("done_err",   64'(bus.done_err_o),   64'(ed.err));
            end
        end
    end

    task automatic job(input logic [AW-1:0] a, input logic [2:0] p, input logic [NC-1:0] m,
                       input logic [NC-1:0] acked, input logic dirty, input logic err,
                       input bit expect_done);
        b_exp_t    eb;
        done_exp_t ed;
        int n;
        for (int k = 0; k < int'(NC); k++) begin
            if (m[k]) begin
                eb.src = SW'(k); eb.param = p; eb.addr = a;
                exp_b.push_back(eb);
            end
        end
        if (expect_done) begin
            ed.acked = acked; ed.dirty = dirty; ed.err = err;
            exp_done.push_back(ed);
        end
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = a;
        bus.req_param_i = p;
        bus.req_mask_i  = m;
        n = 0;
        @(negedge clk);
        while (bus.req_ready_o !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) timeout_fail("req_accept");
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
    endtask

    task automatic c_beat(input logic [2:0] op, input logic [2:0] p, input logic [SW-1:0] src,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n;
        bus.tl_c_valid_i   = 1'b1;
        bus.tl_c_opcode_i  = op;
        bus.tl_c_param_i   = p;
        bus.tl_c_source_i  = src;
        bus.tl_c_address_i = a;
        bus.tl_c_data_i    = d;
        bus.tl_c_corrupt_i = 1'b0;
        n = 0;
        @(negedge clk);
        while (bus.tl_c_ready_o !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) timeout_fail("c_handshake");
        @(posedge clk); #1;
        bus.tl_c_valid_i = 1'b0;
    endtask

    task automatic send_data(input logic [SW-1:0] src, input logic [AW-1:0] a,
                             input logic [DW-1:0] base, input bit fwd);
        wb_exp_t ew;
        for (int i = 0; i < int'(NB); i++) begin
            if (fwd) begin
                ew.data = base + DW'(i); ew.last = (i == int'(NB) - 1);
                exp_wb.push_back(ew);
            end
            c_beat(3'd5, 3'd0, src, a, base + DW'(i));
        end
    endtask

    task automatic wait_b();
        int n;
        n = 0;
        @(negedge clk);
        while (bus.tl_b_valid_o === 1'b1 && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) timeout_fail("b_drain");
        @(posedge clk); #1;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        @(negedge clk);
        while (bus.done_o !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) timeout_fail("done_wait");
        @(posedge clk); #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_req_ready"}, 64'(bus.req_ready_o),  64'd1);
        chk({tag, "_b_valid"},   64'(bus.tl_b_valid_o), 64'd0);
        chk({tag, "_b_address"}, bus.tl_b_address_o,   64'd0);
        chk({tag, "_c_ready"},   64'(bus.tl_c_ready_o), 64'd0);
        chk({tag, "_wb_valid"},  64'(bus.wb_valid_o),   64'd0);
        chk({tag, "_wb_data"},   bus.wb_data_o,         64'd0);
        chk({tag, "_done"},      64'(bus.done_o),       64'd0);
        chk({tag, "_acked"},     64'(bus.done_acked_o), 64'd0);
    endtask

    initial begin
        wb_exp_t ew;
        bus.req_valid_i    = 1'b0;
        bus.req_addr_i     = '0;
        bus.req_param_i    = '0;
        bus.req_mask_i     = '0;
        bus.tl_b_ready_i   = 1'b1;
        bus.tl_c_valid_i   = 1'b0;
        bus.tl_c_opcode_i  = '0;
        bus.tl_c_param_i   = '0;
        bus.tl_c_source_i  = '0;
        bus.tl_c_address_i = '0;
        bus.tl_c_data_i    = '0;
        bus.tl_c_corrupt_i = 1'b0;
        bus.wb_ready_i     = 1'b1;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_quiet("reset");
        @(posedge clk); #1;

        // Single client, ProbeAck TtoN
        job(64'h1000, 3'd2, 2'b01, 2'b01, 1'b0, 1'b0, 1'b1);
        wait_b();
        c_beat(3'd4, 3'd1, 4'd0, 64'h1000, '0);
        wait_done();

        // Two clients, client 1 returns dirty data 0..7
        job(64'h2040, 3'd1, 2'b11, 2'b11, 1'b1, 1'b0, 1'b1);
        wait_b();
        c_beat(3'd4, 3'd4, 4'd0, 64'h2040, '0);
        send_data(4'd1, 64'h2040, 64'd0, 1'b1);
        wait_done();

        // Writeback backpressure for 3 cycles before beat 3
        job(64'h3000, 3'd1, 2'b01, 2'b01, 1'b1, 1'b0, 1'b1);
        wait_b();
        for (int i = 0; i < int'(NB); i++) begin
            ew.data = 64'hA0 + 64'(i); ew.last = (i == int'(NB) - 1);
            exp_wb.push_back(ew);
            if (i == 3) begin
                bus.wb_ready_i     = 1'b0;
                bus.tl_c_valid_i   = 1'b1;
                bus.tl_c_opcode_i  = 3'd5;
                bus.tl_c_param_i   = 3'd0;
                bus.tl_c_source_i  = 4'd0;
                bus.tl_c_address_i = 64'h3000;
                bus.tl_c_data_i    = ew.data;
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_c_ready",  64'(bus.tl_c_ready_o), 64'd0);
                    chk("stall_wb_valid", 64'(bus.wb_valid_o),   64'd1);
                end
                @(posedge clk); #1;
                bus.wb_ready_i = 1'b1;
            end
            c_beat(3'd5, 3'd0, 4'd0, 64'h3000, ew.data);
        end
        wait_done();

        // Probe 1 stalled on B while client 0 acks inside SEND
        job(64'h4000, 3'd0, 2'b11, 2'b11, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        bus.tl_b_ready_i = 1'b0;
        c_beat(3'd4, 3'd3, 4'd0, 64'h4000, '0);
        repeat (4) begin
            @(negedge clk);
            chk("stall_b_valid",  64'(bus.tl_b_valid_o),  64'd1);
            chk("stall_b_source", 64'(bus.tl_b_source_o), 64'd1);
            chk("stall_b_addr",   bus.tl_b_address_o,     64'h4000);
        end
        @(posedge clk); #1;
        bus.tl_b_ready_i = 1'b1;
        wait_b();
        c_beat(3'd4, 3'd3, 4'd1, 64'h4000, '0);
        wait_done();

        // Unknown source 3 is consumed and flagged
        job(64'h5000, 3'd2, 2'b01, 2'b01, 1'b0, 1'b1, 1'b1);
        wait_b();
        c_beat(3'd4, 3'd1, 4'd3, 64'h5000, '0);
        c_beat(3'd4, 3'd1, 4'd0, 64'h5000, '0);
        wait_done();

        // Address mismatch still completes the client but flags error
        job(64'h1000, 3'd2, 2'b01, 2'b01, 1'b0, 1'b1, 1'b1);
        wait_b();
        c_beat(3'd4, 3'd1, 4'd0, 64'h2000, '0);
        wait_done();

        // Second ProbeAckData in one job is swallowed, not forwarded
        job(64'h6000, 3'd1, 2'b11, 2'b11, 1'b1, 1'b1, 1'b1);
        wait_b();
        send_data(4'd0, 64'h6000, 64'h600, 1'b1);
        send_data(4'd1, 64'h6000, 64'h610, 1'b0);
        wait_done();

        // Empty mask completes with nothing acked
        job(64'h7700, 3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
        wait_done();

        // Reset during beat 4 abandons the job
        job(64'h7000, 3'd2, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
        wait_b();
        for (int i = 0; i < 4; i++) begin
            ew.data = 64'h70 + 64'(i); ew.last = 1'b0;
            exp_wb.push_back(ew);
            c_beat(3'd5, 3'd0, 4'd0, 64'h7000, ew.data);
        end
        ew.data = 64'h74; ew.last = 1'b0;
        exp_wb.push_back(ew);
        bus.tl_c_valid_i = 1'b1;
        bus.tl_c_data_i  = ew.data;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.tl_c_valid_i = 1'b0;
        @(negedge clk);
        chk_quiet("midreset");
        @(posedge clk); #1;

        job(64'h8000, 3'd1, 2'b10, 2'b10, 1'b0, 1'b0, 1'b1);
        wait_b();
        c_beat(3'd4, 3'd1, 4'd1, 64'h8000, '0);
        wait_done();

        repeat (3) @(posedge clk);
        chk("b_queue_drained",    64'(exp_b.size()),    64'd0);
        chk("wb_queue_drained",   64'(exp_wb.size()),   64'd0);
        chk("done_queue_drained", 64'(exp_done.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/tl_probe_engine.md
Name: tl_probe_engine

Overview:
- Manager-side probe sequencer for the L2/directory.
- Accepts one probe job: address, cap param, client mask. Issues a TileLink Probe on channel B to each selected client.
- Collects ProbeAck/ProbeAckData on channel C and forwards dirty data beats to a writeback stream.
- Reports one completion per job: acked-client mask, dirty flag, error flag.

Parameters:
NUM_CLIENTS, 2, number of coherent clients; client k uses source id SRC_BASE+k
SRC_BASE, 0, source id of client 0
SRC_W, 4, source field width
ADDR_W, 64, address width
DATA_W, 64, data beat width
BEATS, 8, beats per ProbeAckData (64-byte line)
TIMEOUT_CYCLES, 1024, watchdog limit (optional feature only)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
req_valid_i  in  1  job request valid
req_ready_o  out  1  engine idle, can accept a job
req_addr_i  in  ADDR_W  line address
req_param_i  in  3  cap: toT=0, toB=1, toN=2
req_mask_i  in  NUM_CLIENTS  clients to probe
tl_b_valid_o  out  1  Probe valid
tl_b_ready_i  in  1  Probe ready
tl_b_opcode_o  out  3  always B_PROBE (6)
tl_b_param_o  out  3  latched cap
tl_b_size_o  out  4  always 6
tl_b_source_o  out  SRC_W  SRC_BASE+k
tl_b_address_o  out  ADDR_W  latched address
tl_b_mask_o  out  DATA_W/8  all ones
tl_c_valid_i  in  1  C beat valid
tl_c_ready_o  out  1  C beat ready
tl_c_opcode_i  in  3  ProbeAck=4, ProbeAckData=5
tl_c_param_i  in  3  shrink/report param
tl_c_source_i  in  SRC_W  responding client
tl_c_address_i  in  ADDR_W  response address
tl_c_data_i  in  DATA_W  beat data
tl_c_corrupt_i  in  1  corrupt flag
wb_valid_o  out  1  dirty beat valid
wb_ready_i  in  1  dirty beat ready
wb_data_o  out  DATA_W  dirty beat data
wb_last_o  out  1  last dirty beat
done_o  out  1  one-cycle completion pulse
done_acked_o  out  NUM_CLIENTS  clients that acked
done_dirty_o  out  1  dirty data was forwarded
done_err_o  out  1  protocol error seen

Behaviour:
- Reset (rst_i sampled high at a clk_i edge): state IDLE; todo, pending, acked, err, dirty and beat counter cleared.
  - All valid/done outputs 0, req_ready_o 1 after reset, all other outputs 0.
  - Reset mid-job abandons it; partially accepted C beats are dropped; no done pulse.
- States: IDLE, SEND, COLLECT, DONE.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i, latch address, param and mask; todo=mask; pending=0.
  - Mask==0 -> DONE next cycle. Otherwise -> SEND.
- SEND:
  - tl_b_valid_o=1 for the lowest set bit k of todo; source=SRC_BASE+k.
  - On tl_b_ready_i: clear todo[k], set pending[k].
  - Fields are stable while valid and not ready.
  - When todo becomes empty -> COLLECT.
  - C responses are accepted in SEND as well as COLLECT: acks may overtake remaining probes.
- C handling (SEND/COLLECT): client index k = tl_c_source_i - SRC_BASE.
  - ProbeAck: tl_c_ready_o=1; on handshake clear pending[k], set acked[k].
  - ProbeAckData: wb_valid_o=tl_c_valid_i; tl_c_ready_o=wb_ready_i; wb_data_o=tl_c_data_i (combinational pass-through).
    - Beat counter increments on each handshake; wb_last_o=1 when counter==BEATS-1.
    - On the last beat: counter wraps to 0, clear pending[k], set acked[k], set dirty.
  - Error cases set err:
    - source not pending (including out of range), or mid-burst source change
    - address mismatch vs latched address
    - tl_c_corrupt_i=1
    - opcode not 4/5
    - a second ProbeAckData within one job; that burst is accepted with tl_c_ready_o=1 and not forwarded.
  - Unexpected-source beats are consumed and dropped.
  - Simultaneous B and C handshakes in one cycle are both honoured.
- COLLECT: when pending==0 and todo==0 -> DONE.
- DONE:
  - done_o=1 for one cycle with done_acked_o=acked, done_dirty_o=dirty, done_err_o=err.
  - Then -> IDLE, clearing all job state.
- tl_c_ready_o=0 in IDLE and DONE.

Optional Feature:
- TL_PROBE_TIMEOUT_EN defined:
  - A counter runs in SEND/COLLECT and resets on every B or C handshake.
  - Reaching TIMEOUT_CYCLES forces DONE with done_err_o=1; done_acked_o shows only clients actually acked.
- Undefined: no counter; the engine waits indefinitely.

Test Plan:
- Mask=2'b01, addr 0x1000, param toN; client 0 replies ProbeAck TtoN -> one B beat with source 0, opcode 6, param 2; done_o with acked=01, dirty=0, err=0; wb_valid_o never 1.
- Mask=2'b11; client 1 replies ProbeAckData with 8 beats of data 0..7 -> B beats for source 0 then 1; wb beats 0..7 with wb_last_o on beat 7; done acked=11, dirty=1, err=0.
- wb_ready_i deasserted for 3 cycles mid-burst -> tl_c_ready_o low for those cycles; no beat lost or duplicated.
- tl_b_ready_i held low 5 cycles while client 0 acks early -> ack accepted in SEND; B fields stable; done after client 1 ack.
- ProbeAck from source 3 or with address 0x2000 -> beat consumed; done_err_o=1 on completion.
- Reset asserted on beat 4 of a ProbeAckData -> next cycle all outputs 0 and req_ready_o=1; a new job then completes normally.
